chien_search_ctrl: RTL and testbench

Sequencer for the Chien search stage of the RS(15,11) decoder over GF(16) (primitive polynomial x^4+x+1, alpha = 4'h2). It accepts the error-locator polynomial Lambda(x) = L0 + L1·x + L2·x^2 from the key-equation solver and owns the per-term Chien registers (term 1 stepped by alpha, term 2 by alpha^2). It steps them through all 15 field elements and emits a per-symbol error flag stream in output-symbol order (position 14 first). It also collects up to two error positions and reports root-count failure to the corrector.

---
 rtl/chien_search_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_chien_search_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/chien_search_ctrl.sv
// chien_search_ctrl
// Chien search sequencer for the RS(15,11) decoder over GF(16) (x^4+x+1, alpha=2).
// It evaluates Lambda(x) = L0 + L1*x + L2*x^2 at alpha^1..alpha^15. Each step
// produces one flag for codeword positions 14 down to 0. The block also records
// up to two error positions and flags a root-count failure.
//
// Ports:
//   CLK, RESET           rising-edge clock, async active-high reset
//   START                begin a search (sampled only in IDLE)
//   LAMBDA_0/1/2         locator coefficients, sampled with START
//   LAMBDA_DEG           locator degree from the key-equation solver
//   BUSY                 search in progress
//   POS_VALID/IDX/ERR    per-position flag stream, position 14 first
//   ERR_POS_0/1          first / second root positions found
//   ERR_COUNT            roots found, saturating at 2
//   ROOT_FAIL            uncorrectable pattern
//   DONE                 single-cycle completion pulse
module chien_search_ctrl (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic [3:0] LAMBDA_0,
  input  logic [3:0] LAMBDA_1,
  input  logic [3:0] LAMBDA_2,
  input  logic [1:0] LAMBDA_DEG,
  output logic       BUSY,
  output logic       POS_VALID,
  output logic [3:0] POS_IDX,
  output logic       POS_ERR,
  output logic [3:0] ERR_POS_0,
  output logic [3:0] ERR_POS_1,
  output logic [1:0] ERR_COUNT,
  output logic       ROOT_FAIL,
  output logic       DONE
);

  localparam int unsigned SYM_W = 4;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned DEG_W = 2;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(15);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    FIN    = 2'd2
  } state_t;

  // Constant multiply by alpha: shift left, fold x^4 back in as x+1.
  function automatic logic [SYM_W-1:0] gf_mul_a(input logic [SYM_W-1:0] a);
    gf_mul_a = {a[2:0], 1'b0} ^ (a[3] ? SYM_W'(4'h3) : SYM_W'(4'h0));
  endfunction

  // Constant multiply by alpha^2.
  function automatic logic [SYM_W-1:0] gf_mul_a2(input logic [SYM_W-1:0] a);
    gf_mul_a2 = gf_mul_a(gf_mul_a(a));
  endfunction

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [SYM_W-1:0] l0, l0_nxt;
  logic [SYM_W-1:0] r1, r1_nxt;
  logic [SYM_W-1:0] r2, r2_nxt;
  logic [DEG_W-1:0] deg, deg_nxt;
  logic             overflow, overflow_nxt;

  logic             busy_nxt;
  logic             pos_valid_nxt;
  logic [CNT_W-1:0] pos_idx_nxt;
  logic             pos_err_nxt;
  logic [SYM_W-1:0] err_pos_0_nxt;
  logic [SYM_W-1:0] err_pos_1_nxt;
  logic [1:0]       err_count_nxt;
  logic             root_fail_nxt;
  logic             done_nxt;

  logic [SYM_W-1:0] eval;
  logic             is_root;

  // Lambda evaluated at the current field element.
  assign eval    = l0 ^ r1 ^ r2;
  assign is_root = (eval == SYM_W'(0));

  // State and datapath registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      cnt       <= '0;
      l0        <= '0;
      r1        <= '0;
      r2        <= '0;
      deg       <= '0;
      overflow  <= 1'b0;
      BUSY      <= 1'b0;
      POS_VALID <= 1'b0;
      POS_IDX   <= '0;
      POS_ERR   <= 1'b0;
      ERR_POS_0 <= '0;
      ERR_POS_1 <= '0;
      ERR_COUNT <= '0;
      ROOT_FAIL <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      l0        <= l0_nxt;
      r1        <= r1_nxt;
      r2        <= r2_nxt;
      deg       <= deg_nxt;
      overflow  <= overflow_nxt;
      BUSY      <= busy_nxt;
      POS_VALID <= pos_valid_nxt;
      POS_IDX   <= pos_idx_nxt;
      POS_ERR   <= pos_err_nxt;
      ERR_POS_0 <= err_pos_0_nxt;
      ERR_POS_1 <= err_pos_1_nxt;
      ERR_COUNT <= err_count_nxt;
      ROOT_FAIL <= root_fail_nxt;
      DONE      <= done_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    l0_nxt        = l0;
    r1_nxt        = r1;
    r2_nxt        = r2;
    deg_nxt       = deg;
    overflow_nxt  = overflow;
    busy_nxt      = BUSY;
    pos_valid_nxt = 1'b0;
    pos_idx_nxt   = POS_IDX;
    pos_err_nxt   = POS_ERR;
    err_pos_0_nxt = ERR_POS_0;
    err_pos_1_nxt = ERR_POS_1;
    err_count_nxt = ERR_COUNT;
    root_fail_nxt = ROOT_FAIL;
    done_nxt      = 1'b0;

    case (state)
      IDLE: begin
        if (START) begin
          l0_nxt        = LAMBDA_0;
          r1_nxt        = gf_mul_a(LAMBDA_1);
          r2_nxt        = gf_mul_a2(LAMBDA_2);
          deg_nxt       = LAMBDA_DEG;
          overflow_nxt  = 1'b0;
          err_pos_0_nxt = '0;
          err_pos_1_nxt = '0;
          err_count_nxt = 2'd0;
          root_fail_nxt = 1'b0;
          cnt_nxt       = CNT_W'(1);
          busy_nxt      = 1'b1;
          state_nxt     = SEARCH;
        end
      end

      SEARCH: begin
        // Step cnt tests alpha^cnt, i.e. the locator root of position 15-cnt.
        pos_valid_nxt = 1'b1;
        pos_idx_nxt   = LAST_STEP - cnt;
        pos_err_nxt   = is_root;
        r1_nxt        = gf_mul_a(r1);
        r2_nxt        = gf_mul_a2(r2);
        cnt_nxt       = cnt + CNT_W'(1);
        if (is_root) begin
          case (ERR_COUNT)
            2'd0: begin
              err_pos_0_nxt = LAST_STEP - cnt;
              err_count_nxt = 2'd1;
            end
            2'd1: begin
              err_pos_1_nxt = LAST_STEP - cnt;
              err_count_nxt = 2'd2;
            end
            default: overflow_nxt = 1'b1;
          endcase
        end
        if (cnt == LAST_STEP) begin
          state_nxt = FIN;
        end
      end

      FIN: begin
        done_nxt      = 1'b1;
        root_fail_nxt = overflow | (ERR_COUNT != deg);
        busy_nxt      = 1'b0;
        state_nxt     = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_chien_search_ctrl.sv
// tb_chien_search_ctrl
// Directed bench for chien_search_ctrl. Locators with hand-derived root
// positions are driven, and the flag stream and the results are checked
// cycle by cycle.
module tb_chien_search_ctrl;

  logic       CLK;
  logic       RESET;
  logic       START;
  logic [3:0] LAMBDA_0;
  logic [3:0] LAMBDA_1;
  logic [3:0] LAMBDA_2;
  logic [1:0] LAMBDA_DEG;
  logic       BUSY;
  logic       POS_VALID;
  logic [3:0] POS_IDX;
  logic       POS_ERR;
  logic [3:0] ERR_POS_0;
  logic [3:0] ERR_POS_1;
  logic [1:0] ERR_COUNT;
  logic       ROOT_FAIL;
  logic       DONE;

  int errors = 0;
  int checks = 0;

  chien_search_ctrl dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .START      (START),
    .LAMBDA_0   (LAMBDA_0),
    .LAMBDA_1   (LAMBDA_1),
    .LAMBDA_2   (LAMBDA_2),
    .LAMBDA_DEG (LAMBDA_DEG),
    .BUSY       (BUSY),
    .POS_VALID  (POS_VALID),
    .POS_IDX    (POS_IDX),
    .POS_ERR    (POS_ERR),
    .ERR_POS_0  (ERR_POS_0),
    .ERR_POS_1  (ERR_POS_1),
    .ERR_COUNT  (ERR_COUNT),
    .ROOT_FAIL  (ROOT_FAIL),
    .DONE       (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Caller must be at a negedge. Returns at the negedge of the DONE cycle.
  // With hold=1 START stays high through the whole search.
  task automatic run_search(input string name,
                            input logic [3:0] l0, input logic [3:0] l1,
                            input logic [3:0] l2, input logic [1:0] deg,
                            input logic [14:0] mask,
                            input logic [3:0] p0, input logic [3:0] p1,
                            input logic [1:0] cnt, input logic fail,
                            input logic hold);
    START      = 1'b1;
    LAMBDA_0   = l0;
    LAMBDA_1   = l1;
    LAMBDA_2   = l2;
    LAMBDA_DEG = deg;
    @(posedge CLK);
    #1;
    START      = hold;
    LAMBDA_0   = 4'($urandom);
    LAMBDA_1   = 4'($urandom);
    LAMBDA_2   = 4'($urandom);
    LAMBDA_DEG = 2'($urandom);
    @(negedge CLK);
    check({name, "/busy_acc"},  8'(BUSY), 8'd1);
    check({name, "/valid_acc"}, 8'(POS_VALID), 8'd0);
    check({name, "/cnt_clr"},   8'(ERR_COUNT), 8'd0);
    check({name, "/fail_clr"},  8'(ROOT_FAIL), 8'd0);
    for (int i = 1; i <= 15; i++) begin
      @(negedge CLK);
      check($sformatf("%s/valid%0d", name, i), 8'(POS_VALID), 8'd1);
      check($sformatf("%s/idx%0d", name, i),   8'(POS_IDX), 8'(15 - i));
      check($sformatf("%s/err%0d", name, i),   8'(POS_ERR), 8'(mask[15 - i]));
      check($sformatf("%s/done%0d", name, i),  8'(DONE), 8'd0);
      check($sformatf("%s/busy%0d", name, i),  8'(BUSY), 8'd1);
    end
    @(negedge CLK);
    check({name, "/done"},  8'(DONE), 8'd1);
    check({name, "/busy"},  8'(BUSY), 8'd0);
    check({name, "/valid"}, 8'(POS_VALID), 8'd0);
    check({name, "/pos0"},  8'(ERR_POS_0), 8'(p0));
    check({name, "/pos1"},  8'(ERR_POS_1), 8'(p1));
    check({name, "/count"}, 8'(ERR_COUNT), 8'(cnt));
    check({name, "/fail"},  8'(ROOT_FAIL), 8'(fail));
  endtask

  task automatic check_all_zero(input string name);
    check({name, "/busy"},  8'(BUSY), 8'd0);
    check({name, "/valid"}, 8'(POS_VALID), 8'd0);
    check({name, "/idx"},   8'(POS_IDX), 8'd0);
    check({name, "/err"},   8'(POS_ERR), 8'd0);
    check({name, "/pos0"},  8'(ERR_POS_0), 8'd0);
    check({name, "/pos1"},  8'(ERR_POS_1), 8'd0);
    check({name, "/count"}, 8'(ERR_COUNT), 8'd0);
    check({name, "/fail"},  8'(ROOT_FAIL), 8'd0);
    check({name, "/done"},  8'(DONE), 8'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic seen_done;
    logic seen_valid;
    RESET      = 1'b1;
    START      = 1'b0;
    LAMBDA_0   = '0;
    LAMBDA_1   = '0;
    LAMBDA_2   = '0;
    LAMBDA_DEG = '0;
    repeat (2) @(negedge CLK);
    check_all_zero("reset");
    RESET = 1'b0;
    @(negedge CLK);

    // Errors at positions 10 and 3: (1+a^10 x)(1+a^3 x) = 1 + F x + D x^2.
    run_search("two_err", 4'h1, 4'hF, 4'hD, 2'd2, 15'h0408, 4'd10, 4'd3, 2'd2, 1'b0, 1'b0);
    START = 1'b0;
    repeat (3) @(negedge CLK);
    check("hold/done",  8'(DONE), 8'd0);
    check("hold/pos0",  8'(ERR_POS_0), 8'd10);
    check("hold/count", 8'(ERR_COUNT), 8'd2);

    // 9 = a^14, so the root is at the first step (position 14).
    run_search("first", 4'h1, 4'h9, 4'h0, 2'd1, 15'h4000, 4'd14, 4'd0, 2'd1, 1'b0, 1'b0);
    START = 1'b0;
    @(negedge CLK);
    // 1 + x has root a^15 = 1, i.e. the last step (position 0).
    run_search("last", 4'h1, 4'h1, 4'h0, 2'd1, 15'h0001, 4'd0, 4'd0, 2'd1, 1'b0, 1'b0);
    START = 1'b0;
    @(negedge CLK);
    run_search("deg_mis", 4'h1, 4'h0, 4'h0, 2'd1, 15'h0000, 4'd0, 4'd0, 2'd0, 1'b1, 1'b0);
    START = 1'b0;
    @(negedge CLK);
    run_search("ovf", 4'h0, 4'h0, 4'h0, 2'd2, 15'h7FFF, 4'd14, 4'd13, 2'd2, 1'b1, 1'b0);
    START = 1'b0;
    @(negedge CLK);
    run_search("deg0", 4'h5, 4'h0, 4'h0, 2'd0, 15'h0000, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0);
    START = 1'b0;
    @(negedge CLK);

    // START held through a search, then a back-to-back START in the DONE cycle.
    run_search("held", 4'h1, 4'h9, 4'h0, 2'd1, 15'h4000, 4'd14, 4'd0, 2'd1, 1'b0, 1'b1);
    run_search("b2b", 4'h1, 4'hF, 4'hD, 2'd2, 15'h0408, 4'd10, 4'd3, 2'd2, 1'b0, 1'b0);
    START = 1'b0;
    @(negedge CLK);

    // Reset during the 7th flag cycle.
    START      = 1'b1;
    LAMBDA_0   = 4'h1;
    LAMBDA_1   = 4'hF;
    LAMBDA_2   = 4'hD;
    LAMBDA_DEG = 2'd2;
    @(posedge CLK);
    #1;
    START = 1'b0;
    @(negedge CLK);
    repeat (7) @(negedge CLK);
    check("rst/valid_pre", 8'(POS_VALID), 8'd1);
    check("rst/idx_pre",   8'(POS_IDX), 8'd8);
    check("rst/pos0_pre",  8'(ERR_POS_0), 8'd10);
    RESET = 1'b1;
    #1;
    check_all_zero("rst_mid");
    @(negedge CLK);
    RESET = 1'b0;
    seen_done  = 1'b0;
    seen_valid = 1'b0;
    repeat (20) begin
      @(negedge CLK);
      seen_done  = seen_done | DONE;
      seen_valid = seen_valid | POS_VALID;
    end
    check("rst/no_done",   8'(seen_done), 8'd0);
    check("rst/no_resume", 8'(seen_valid), 8'd0);
    run_search("after_rst", 4'h1, 4'h1, 4'h0, 2'd1, 15'h0001, 4'd0, 4'd0, 2'd1, 1'b0, 1'b0);
    START = 1'b0;
    @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
